// File: rtl/muls_share_arb_if.sv
// Request/response bus between the two requesters and the shared multiplier arbiter.
// master = requester side, slave = arbiter side.
interface muls_share_arb_if #(
   parameter int unsigned X_WIDTH = 2,
   parameter int unsigned Y_WIDTH = 2,
   parameter int unsigned P_WIDTH = X_WIDTH + Y_WIDTH
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [X_WIDTH-1:0] req_x0;
   logic [X_WIDTH-1:0] req_x1;
   logic [Y_WIDTH-1:0] req_y0;
   logic [Y_WIDTH-1:0] req_y1;
   logic [1:0]         resp_valid;
   logic [1:0]         resp_ready;
   logic [P_WIDTH-1:0] resp_p;
   logic               resp_s;

   modport master (
      output req_valid, req_x0, req_x1, req_y0, req_y1, resp_ready,
      input  req_ready, resp_valid, resp_p, resp_s
   );

   modport slave (
      input  req_valid, req_x0, req_x1, req_y0, req_y1, resp_ready,
      output req_ready, resp_valid, resp_p, resp_s
   );
endinterface

// File: rtl/muls_share_arb.sv
// Two-requester round-robin arbiter/sequencer for the shared signed multiplier core.
// Optional per-requester grant counters enabled by defining MULS_ARB_STATS_EN.
module muls_share_arb #(
   parameter int unsigned X_WIDTH = 2,
   parameter int unsigned Y_WIDTH = 2,
   parameter int unsigned P_WIDTH = X_WIDTH + Y_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   muls_share_arb_if.slave    bus,
   output logic               busy,
   output logic [X_WIDTH-1:0] mul_x,
   output logic [Y_WIDTH-1:0] mul_y,
   input  logic [P_WIDTH-1:0] mul_p,
   input  logic               mul_s,
   input  logic               mul_rdy
`ifdef MULS_ARB_STATS_EN
   ,
   output logic [7:0]         grant_cnt0,
   output logic [7:0]         grant_cnt1
`endif
);

   localparam int unsigned N_REQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   logic               last_grant;
   logic               gnt_id;
   logic [X_WIDTH-1:0] op_x;
   logic [Y_WIDTH-1:0] op_y;
   logic [P_WIDTH-1:0] res_p;
   logic               res_s;
   logic [N_REQ-1:0]   resp_vld;

   logic               grant0;
   logic               grant1;
   logic               open;
   logic               take;

   // Round-robin pick; the requester served last loses a tie.
   always_comb begin
      grant0 = bus.req_valid[0] & (~bus.req_valid[1] | last_grant);
      grant1 = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
      open   = (state == IDLE) & ~reset;
      take   = open & (grant0 | grant1);
   end

   assign bus.req_ready  = {grant1, grant0} & {N_REQ{open}};
   assign bus.resp_valid = resp_vld;
   assign bus.resp_p     = res_p;
   assign bus.resp_s     = res_s;
   assign mul_x          = op_x;
   assign mul_y          = op_y;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         op_x       <= '0;
         op_y       <= '0;
         res_p      <= '0;
         res_s      <= 1'b0;
         resp_vld   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  op_x       <= grant1 ? bus.req_x1 : bus.req_x0;
                  op_y       <= grant1 ? bus.req_y1 : bus.req_y0;
                  gnt_id     <= grant1;
                  last_grant <= grant1;
                  busy       <= 1'b1;
                  state      <= MUL;
               end
            end
            MUL: begin
               if (mul_rdy) begin
                  res_p    <= mul_p;
                  res_s    <= mul_s;
                  resp_vld <= gnt_id ? 2'b10 : 2'b01;
                  state    <= RESP;
               end
            end
            RESP: begin
               // Only the owner's ready bit can release the response.
               if (bus.resp_ready[gnt_id]) begin
                  resp_vld <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               resp_vld <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

`ifdef MULS_ARB_STATS_EN
   localparam int unsigned CNT_WIDTH = 8;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Saturating accepted-request counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (take) begin
         if (grant0 && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
         if (grant1 && grant_cnt1 != CNT_MAX) grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_muls_share_arb.sv
// Self-checking bench for muls_share_arb: directed scenarios plus randomized traffic
// scored against a transaction-level model. Grant counters checked when MULS_ARB_STATS_EN is defined.
module tb_muls_share_arb;

   localparam int unsigned XW = 2;
   localparam int unsigned YW = 2;
   localparam int unsigned PW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muls_share_arb_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .P_WIDTH(PW)) bus ();

   logic          busy;
   logic [XW-1:0] mul_x;
   logic [YW-1:0] mul_y;
   logic [PW-1:0] mul_p;
   logic          mul_s;
   logic          mul_rdy;
`ifdef MULS_ARB_STATS_EN
   logic [7:0]    grant_cnt0;
   logic [7:0]    grant_cnt1;
`endif

   muls_share_arb #(.X_WIDTH(XW), .Y_WIDTH(YW), .P_WIDTH(PW)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .busy    (busy),
      .mul_x   (mul_x),
      .mul_y   (mul_y),
      .mul_p   (mul_p),
      .mul_s   (mul_s),
      .mul_rdy (mul_rdy)
`ifdef MULS_ARB_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   function automatic int sval(input logic [1:0] v);
      return v[1] ? int'(v) - 4 : int'(v);
   endfunction

   // Multiplier core stand-in: sign-magnitude product, junk while not ready.
   always_comb begin
      int prod;
      prod  = sval(mul_x) * sval(mul_y);
      mul_s = (prod < 0) ^ ~mul_rdy;
      mul_p = PW'(prod < 0 ? -prod : prod) ^ {PW{~mul_rdy}};
   end

   int checks = 0;
   int passes = 0;

   // Transaction model state
   int         last_served;
   int         exp_cnt [2];
   bit         pend [2];
   logic [1:0] px [2];
   logic [1:0] py [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] ref_mul(input logic [1:0] x, input logic [1:0] y);
      int v;
      v = sval(x) * sval(y);
      return {v < 0, 4'(v < 0 ? -v : v)};
   endfunction

   function automatic int winner();
      if (pend[0] && pend[1]) return (last_served == 0) ? 1 : 0;
      if (pend[0]) return 0;
      if (pend[1]) return 1;
      return -1;
   endfunction

   task automatic drive_reqs();
      bus.req_valid = {pend[1], pend[0]};
      bus.req_x0    = px[0];
      bus.req_y0    = py[0];
      bus.req_x1    = px[1];
      bus.req_y1    = py[1];
   endtask

   // One full request/response; mode 0 drops the winner, 1 re-requests same operands, 2 new random.
   task automatic transact(input int stall, input int hold, input int mode, output int g);
      int         w;
      int         lat;
      int         s;
      logic [1:0] onehot;
      logic [4:0] e;
      drive_reqs();
      #1;
      w      = winner();
      onehot = (w == 1) ? 2'b10 : 2'b01;
      g      = (bus.req_ready == 2'b10) ? 1 : 0;
      chk("req_ready_grant", 32'(bus.req_ready), 32'(onehot));
      e       = ref_mul(px[w], py[w]);
      mul_rdy = (stall == 0);
      tick();
      lat         = 1;
      last_served = w;
      if (exp_cnt[w] < 255) exp_cnt[w]++;
      pend[w] = (mode != 0);
      if (mode == 2) begin
         px[w] = 2'($urandom);
         py[w] = 2'($urandom);
      end
      drive_reqs();
      chk("busy_mul", 32'(busy), 32'd1);
      s = 0;
      while (bus.resp_valid == 2'b00 && lat < 40) begin
         chk("req_ready_mul", 32'(bus.req_ready), 32'd0);
         tick();
         lat++;
         s++;
         if (s >= stall) mul_rdy = 1'b1;
      end
      chk("latency", 32'(lat), 32'(2 + stall));
      chk("resp_valid", 32'(bus.resp_valid), 32'(onehot));
      chk("resp_p", 32'(bus.resp_p), 32'(e[3:0]));
      chk("resp_s", 32'(bus.resp_s), 32'(e[4]));
      bus.resp_ready = ~onehot;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", 32'(bus.resp_valid), 32'(onehot));
         chk("hold_p", 32'({bus.resp_s, bus.resp_p}), 32'(e));
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = onehot;
      tick();
      bus.resp_ready = 2'b00;
      chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_resp_hold", 32'({bus.resp_s, bus.resp_p}), 32'(e));
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, 32'({bus.req_ready, bus.resp_valid, bus.resp_p, bus.resp_s, busy, mul_x, mul_y}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1);
   end

   initial begin
      int g;
      reset          = 1'b1;
      mul_rdy        = 1'b1;
      bus.req_valid  = 2'b00;
      bus.req_x0     = '0;
      bus.req_y0     = '0;
      bus.req_x1     = '0;
      bus.req_y1     = '0;
      bus.resp_ready = 2'b00;
      last_served    = 1;
      exp_cnt[0]     = 0;
      exp_cnt[1]     = 0;
      pend[0]        = 0;
      pend[1]        = 0;
      px[0] = '0; py[0] = '0; px[1] = '0; py[1] = '0;
      #12;
      chk_all_zero("reset_outputs");
      reset = 1'b0;
      tick();

      // Single request: -2 * 1
      pend[0] = 1; px[0] = 2'b10; py[0] = 2'b01;
      transact(0, 0, 0, g);
      chk("single_ref_p", 32'(bus.resp_p), 32'd2);
      chk("single_ref_s", 32'(bus.resp_s), 32'd1);

      // Contention: both held valid, grants alternate
      pend[0] = 1; px[0] = 2'b11; py[0] = 2'b11;
      pend[1] = 1; px[1] = 2'b01; py[1] = 2'b01;
      for (int i = 0; i < 4; i++) begin
         transact(0, 0, 1, g);
         chk("rr_order", 32'(g), 32'((i + 1) % 2));
         chk("rr_p1", 32'({bus.resp_s, bus.resp_p}), 32'd1);
      end
      pend[0] = 0; pend[1] = 0;

      // Backpressure with the other requester waiting
      pend[0] = 1; px[0] = 2'($urandom); py[0] = 2'($urandom);
      pend[1] = 1; px[1] = 2'($urandom); py[1] = 2'($urandom);
      transact(0, 10, 0, g);
      transact(0, 0, 0, g);

      // Slow multiplier
      pend[1] = 1; px[1] = 2'b10; py[1] = 2'b10;
      transact(3, 0, 0, g);

      // Randomized traffic
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1;
               px[i]   = 2'($urandom);
               py[i]   = 2'($urandom);
            end
         end
         if (!pend[0] && !pend[1]) begin
            pend[r % 2] = 1;
            px[r % 2]   = 2'($urandom);
            py[r % 2]   = 2'($urandom);
         end
         transact($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), g);
      end

`ifdef MULS_ARB_STATS_EN
      chk("cnt0_mid", 32'(grant_cnt0), 32'(exp_cnt[0]));
      chk("cnt1_mid", 32'(grant_cnt1), 32'(exp_cnt[1]));
`endif

      // Async reset mid-cycle while in RESP
      pend[0] = 1; px[0] = 2'b11; py[0] = 2'b10;
      pend[1] = 1; px[1] = 2'b01; py[1] = 2'b11;
      drive_reqs();
      tick();
      tick();
      chk("pre_reset_resp", 32'(bus.resp_valid != 2'b00), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      last_served = 1;
      exp_cnt[0]  = 0;
      exp_cnt[1]  = 0;
      tick();
      chk_all_zero("reset_held");
      reset = 1'b0;
      transact(0, 0, 1, g);
      chk("first_after_reset", 32'(g), 32'd0);
      transact(0, 0, 0, g);
      transact(0, 0, 0, g);

`ifdef MULS_ARB_STATS_EN
      // Saturation of requester 1 counter
      pend[0] = 0;
      for (int i = 0; i < 300; i++) begin
         pend[1] = 1;
         px[1]   = 2'($urandom);
         py[1]   = 2'($urandom);
         transact(0, 0, 0, g);
      end
      chk("cnt1_sat", 32'(grant_cnt1), 32'd255);
      chk("cnt0_kept", 32'(grant_cnt0), 32'(exp_cnt[0]));
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/muls_share_arb.md
Name: muls_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared signed small-operand multiplier core.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier from registered operands.
- Captures the sign-magnitude result and returns it on a shared response bus to the granted requester.
- Sits between the io_in/io_out pin wrapper logic and the multiplier instance.

Parameters:
- X_WIDTH, 2, multiplicand width (two's complement)
- Y_WIDTH, 2, multiplier width (two's complement)
- P_WIDTH, 4, product magnitude width (X_WIDTH+Y_WIDTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid, bit i = requester i
- req_x0, req_x1  in  X_WIDTH  operand x per requester
- req_y0, req_y1  in  Y_WIDTH  operand y per requester
- req_ready  out  2  request accepted when valid&ready in the same cycle
- resp_valid  out  2  response valid, one-hot to the owning requester
- resp_ready  in  2  response consumed when valid&ready
- resp_p  out  P_WIDTH  product magnitude, shared bus
- resp_s  out  1  product sign, shared bus
- busy  out  1  high in every state except IDLE
- mul_x  out  X_WIDTH  operand to multiplier
- mul_y  out  Y_WIDTH  operand to multiplier
- mul_p  in  P_WIDTH  multiplier magnitude
- mul_s  in  1  multiplier sign
- mul_rdy  in  1  multiplier result valid; tie 1 for a combinational core

Behaviour:
- Reset (async, active-high):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - op_x, op_y, res_p, res_s, gnt_id all 0.
  - All outputs 0.
- FSM states: IDLE -> MUL -> RESP -> IDLE.
- IDLE grant rule:
  - Both req_valid set: grant the requester != last_grant.
  - One set: grant that requester.
- IDLE handshake:
  - req_ready[g] is combinational: (state==IDLE) & grant_g. At most one bit is ever set; req_ready=0 in all other states.
  - On handshake: capture req_x[g]/req_y[g] into op_x/op_y, set gnt_id=g and last_grant=g, go to MUL.
- Requester drops req_valid before acceptance: no effect, no state change.
- mul_x=op_x and mul_y=op_y at all times (registered, glitch-free).
- MUL: stay while mul_rdy=0. When mul_rdy=1, register mul_p/mul_s into res_p/res_s and go to RESP.
- RESP:
  - resp_valid[gnt_id]=1, resp_p=res_p, resp_s=res_s, all held stable.
  - Exit to IDLE on resp_ready[gnt_id]. resp_ready on the non-owning bit is ignored.
- Outside RESP: resp_valid=0, and resp_p/resp_s hold their last values.
- Latency with mul_rdy=1: accept at edge N, resp_valid high from the cycle after edge N+1, i.e. 2 cycles.
- Minimum issue interval: 3 cycles. No request is accepted in the cycle a response is consumed; IDLE always lasts at least 1 cycle.
- Requests arriving during MUL/RESP wait, with valid held, until IDLE.
- Reset mid-operation aborts immediately:
  - The pending response is lost.
  - Both requesters must re-issue.
- Block is arithmetic-transparent: it never alters mul_p/mul_s.

Optional Feature:
- Macro: MULS_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 8 bits each.
  - Each counts accepted requests for its requester, increments on handshake, and saturates at 255.
  - Cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single request, no contention: req_valid=01, x0=2'b10 (-2), y0=2'b01 (1), model multiplier → req_ready=01 for one cycle; resp_valid=01 two cycles later with resp_p=4'd2, resp_s=1; busy high throughout; IDLE after resp_ready=01.
- Contention round-robin: both valid continuously, x0=y0=2'b11 (-1), x1=y1=2'b01 (1) → grants alternate 0,1,0,1 with resp_id order matching; responses p=1,s=0 for both.
- Backpressure: hold resp_ready=00 for 10 cycles in RESP → resp_valid, resp_p, resp_s stable and req_ready=00 throughout; new requests wait.
- Slow multiplier: mul_rdy low for 3 cycles after entering MUL → stays in MUL; response captured only on the mul_rdy=1 cycle; latency 5 cycles.
- Async reset asserted in RESP mid-cycle → all outputs 0 immediately without a clock edge; the first grant after release goes to requester 0 when both are valid.
- Stats (MULS_ARB_STATS_EN defined): 300 accepted requests from requester 1 → grant_cnt1=255 and grant_cnt0 unchanged.
